// File: rtl/fastram_cycle_ctrl.sv
// ============================================================================
// Module   : fastram_cycle_ctrl
// Purpose  : 68030 fast RAM window decode, ACCESS/STERM sequencing with wait
//            states; optional 4-longword burst fills under FASTRAM_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fastram_cycle_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int BURST_WAITS = 1
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic [7:0] A,
  input  logic       A31_24Z,
  input  logic       CONFIGURED,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       DS20,
  input  logic       CBREQ,
  output logic       ACCESS,
  output logic       STERM,
  output logic       CBACK,
  output logic       CIIN,
  output logic [1:0] BEAT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_TERM  = 3'd2,
    S_BWAIT = 3'd3,
    S_BTERM = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] C_WAIT_LOAD  = 3'(WAIT_STATES);
  localparam logic [2:0] C_BURST_LOAD = 3'(BURST_WAITS);
`ifdef FASTRAM_BURST_EN
  localparam logic C_BURST_EN = 1'b1;
`else
  localparam logic C_BURST_EN = 1'b0;
`endif

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       r_burst, w_burst_next;
  logic [1:0] r_beat, w_beat_next;
  logic       r_access, r_sterm, r_cback;
  logic       w_hit, w_start, w_next_acc;

  assign w_hit   = CONFIGURED & A31_24Z & (A[7:5] >= 3'b001) & (A[7:5] <= 3'b100);
  assign w_start = ~AS20 & w_hit & (RW20 | ~DS20);

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_burst_next = r_burst;
    w_beat_next  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_beat_next = 2'd0;
          w_cnt_next  = C_WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            w_next       = S_TERM;
            w_burst_next = C_BURST_EN & ~CBREQ;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_next       = S_TERM;
          w_burst_next = C_BURST_EN & ~CBREQ;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_TERM: begin
        if (r_burst) begin
          w_beat_next = r_beat + 2'd1;
          w_cnt_next  = C_BURST_LOAD;
          w_next      = (BURST_WAITS == 0) ? S_BTERM : S_BWAIT;
        end else begin
          w_next = S_DONE;
        end
      end
      S_BWAIT: begin
        if (r_cnt <= 3'd1) begin
          w_next = S_BTERM;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_BTERM: begin
        // CBREQ negated mid-line means the CPU abandoned the fill.
        if ((r_beat == 2'd3) || CBREQ) begin
          w_next = S_DONE;
        end else begin
          w_beat_next = r_beat + 2'd1;
          w_cnt_next  = C_BURST_LOAD;
          w_next      = (BURST_WAITS == 0) ? S_BTERM : S_BWAIT;
        end
      end
      S_DONE: begin
        if (AS20) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    if ((r_state != S_IDLE) && AS20) w_next = S_IDLE;

    w_next_acc = (w_next == S_WAIT) || (w_next == S_TERM) ||
                 (w_next == S_BWAIT) || (w_next == S_BTERM);
    if (!w_next_acc) w_beat_next = 2'd0;
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_burst  <= 1'b0;
      r_beat   <= 2'd0;
      r_access <= 1'b1;
      r_sterm  <= 1'b1;
      r_cback  <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_burst  <= w_burst_next;
      r_beat   <= w_beat_next;
      r_access <= ~w_next_acc;
      r_sterm  <= ~((w_next == S_TERM) || (w_next == S_BTERM));
      r_cback  <= ~(((w_next == S_TERM) & w_burst_next) ||
                    (w_next == S_BWAIT) || (w_next == S_BTERM));
    end
  end

  assign ACCESS = r_access;
  assign STERM  = r_sterm;
  assign CIIN   = 1'b1;

`ifdef FASTRAM_BURST_EN
  assign CBACK = r_cback;
  assign BEAT  = r_beat;
`else
  logic w_unused_burst;
  assign w_unused_burst = ^{r_cback, r_beat};
  assign CBACK = 1'b1;
  assign BEAT  = 2'd0;
`endif

endmodule

`default_nettype wire
